// File: rtl/mem_controller.sv
// Round-robin arbiter from NUM_CONSUMERS load/store units onto one memory port.
// One transaction in flight; the consumer ready stays high until that consumer drops its valid.
module mem_controller #(
  parameter int unsigned AddrBits     = 8,
  parameter int unsigned DataBits     = 8,
  parameter int unsigned NumConsumers = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumConsumers-1:0]          consumer_read_valid_i,
  input  logic [NumConsumers*AddrBits-1:0] consumer_read_addr_i,
  output logic [NumConsumers-1:0]          consumer_read_ready_o,
  output logic [NumConsumers*DataBits-1:0] consumer_read_data_o,
  input  logic [NumConsumers-1:0]          consumer_write_valid_i,
  input  logic [NumConsumers*AddrBits-1:0] consumer_write_addr_i,
  input  logic [NumConsumers*DataBits-1:0] consumer_write_data_i,
  output logic [NumConsumers-1:0]          consumer_write_ready_o,
  output logic                             mem_read_valid_o,
  output logic [AddrBits-1:0]              mem_read_address_o,
  input  logic                             mem_read_ready_i,
  input  logic [DataBits-1:0]              mem_read_data_i,
  output logic                             mem_write_valid_o,
  output logic [AddrBits-1:0]              mem_write_address_o,
  output logic [DataBits-1:0]              mem_write_data_o,
  input  logic                             mem_write_ready_i
);

  localparam int unsigned IdW = (NumConsumers > 1) ? $clog2(NumConsumers) : 1;
  typedef logic [IdW-1:0] id_t;

  typedef enum logic [2:0] {
    StIdle,
    StReadWait,
    StWriteWait,
    StReadRelay,
    StWriteRelay
  } state_e;

  state_e                         state_q, state_d;
  id_t                            rr_ptr_q, rr_ptr_d;
  id_t                            cur_id_q, cur_id_d;
  logic                           mem_read_valid_q, mem_read_valid_d;
  logic [AddrBits-1:0]            mem_read_address_q, mem_read_address_d;
  logic                           mem_write_valid_q, mem_write_valid_d;
  logic [AddrBits-1:0]            mem_write_address_q, mem_write_address_d;
  logic [DataBits-1:0]            mem_write_data_q, mem_write_data_d;
  logic [NumConsumers-1:0]        read_ready_q, read_ready_d;
  logic [NumConsumers*DataBits-1:0] read_data_q, read_data_d;
  logic [NumConsumers-1:0]        write_ready_q, write_ready_d;

  logic [NumConsumers-1:0] req;
  logic                    grant_found;
  id_t                     grant_id;

  assign req = consumer_read_valid_i | consumer_write_valid_i;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NumConsumers; k++) begin
      idx = (32'(rr_ptr_q) + k) % NumConsumers;
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_id    = id_t'(idx);
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    cur_id_d            = cur_id_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_ready_d        = read_ready_q;
    read_data_d         = read_data_q;
    write_ready_d       = write_ready_q;

    case (state_q)
      StIdle: begin
        if (grant_found) begin
          cur_id_d = grant_id;
          rr_ptr_d = id_t'((32'(grant_id) + 32'd1) % NumConsumers);
          if (consumer_read_valid_i[grant_id]) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = consumer_read_addr_i[32'(grant_id)*AddrBits +: AddrBits];
            state_d            = StReadWait;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = consumer_write_addr_i[32'(grant_id)*AddrBits +: AddrBits];
            mem_write_data_d    = consumer_write_data_i[32'(grant_id)*DataBits +: DataBits];
            state_d             = StWriteWait;
          end
        end
      end
      StReadWait: begin
        if (mem_read_ready_i) begin
          read_data_d[32'(cur_id_q)*DataBits +: DataBits] = mem_read_data_i;
          read_ready_d[cur_id_q] = 1'b1;
          mem_read_valid_d       = 1'b0;
          state_d                = StReadRelay;
        end
      end
      StWriteWait: begin
        if (mem_write_ready_i) begin
          write_ready_d[cur_id_q] = 1'b1;
          mem_write_valid_d       = 1'b0;
          state_d                 = StWriteRelay;
        end
      end
      StReadRelay: begin
        if (!consumer_read_valid_i[cur_id_q]) begin
          read_ready_d[cur_id_q] = 1'b0;
          state_d                = StIdle;
        end
      end
      StWriteRelay: begin
        if (!consumer_write_valid_i[cur_id_q]) begin
          write_ready_d[cur_id_q] = 1'b0;
          state_d                 = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q             <= StIdle;
      rr_ptr_q            <= '0;
      cur_id_q            <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      read_data_q         <= '0;
      write_ready_q       <= '0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      cur_id_q            <= cur_id_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      read_data_q         <= read_data_d;
      write_ready_q       <= write_ready_d;
    end
  end

  assign consumer_read_ready_o  = read_ready_q;
  assign consumer_read_data_o   = read_data_q;
  assign consumer_write_ready_o = write_ready_q;
  assign mem_read_valid_o       = mem_read_valid_q;
  assign mem_read_address_o     = mem_read_address_q;
  assign mem_write_valid_o      = mem_write_valid_q;
  assign mem_write_address_o    = mem_write_address_q;
  assign mem_write_data_o       = mem_write_data_q;

endmodule
